// File: rtl/mult_f32_seq.sv
// Sequential float32 multiplier. The 24x24 mantissa product is built one bit
// per cycle by shift-and-add, then normalized and rounded to nearest even.
// Denormal inputs are flushed to zero and there are no denormal outputs.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; holds m/rdy from the previous operation
// SPECIAL | zero/Inf/NaN operand; publish precomputed result next edge
// MULT    | 24 shift-add iterations into the 48-bit accumulator
// NORM    | normalize, round, range-check the exponent
// DONE    | publish result, raise rdy, drop busy
module mult_f32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        rdy,
  output logic [31:0] m
);

  typedef enum logic [2:0] {S_IDLE, S_SPECIAL, S_MULT, S_NORM, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [47:0]        r_acc;
  logic [47:0]        r_ma;
  logic [23:0]        r_mb;
  logic [4:0]         r_cnt;
  logic signed [9:0]  r_exp;
  logic               r_sign;
  logic [31:0]        r_res;
  logic               r_busy;
  logic               r_rdy;
  logic [31:0]        r_m;

  logic               w_sign;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic               w_is_special;
  logic [31:0]        w_spec_res;

  logic               w_hi;
  logic [22:0]        w_mant;
  logic               w_guard, w_sticky, w_round_up;
  logic [23:0]        w_mant_r;
  logic signed [9:0]  w_exp_r;
  logic [31:0]        w_norm_res;

  assign busy = r_busy;
  assign rdy  = r_rdy;
  assign m    = r_m;

  // Operand classification on the live inputs, used only at the start edge
  always_comb begin
    w_sign       = a[31] ^ b[31];
    w_a_zero     = (a[30:23] == 8'h00);
    w_b_zero     = (b[30:23] == 8'h00);
    w_a_inf      = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    w_b_inf      = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    w_a_nan      = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    w_b_nan      = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    w_is_special = w_a_zero || w_b_zero || (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    w_spec_res   = {w_sign, 31'h0};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
      w_spec_res = 32'h7FC00000;
    else if (w_a_inf || w_b_inf)
      w_spec_res = {w_sign, 8'hFF, 23'h0};
  end

  // Normalize and round the finished accumulator; carry out of the rounded
  // mantissa bumps the exponent and leaves the stored fraction at zero
  always_comb begin
    w_hi       = r_acc[47];
    w_mant     = w_hi ? r_acc[46:24] : r_acc[45:23];
    w_guard    = w_hi ? r_acc[23]    : r_acc[22];
    w_sticky   = w_hi ? (|r_acc[22:0]) : (|r_acc[21:0]);
    w_round_up = w_guard && (w_sticky || w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {23'h0, w_round_up};
    w_exp_r    = r_exp + $signed({9'h0, w_hi}) + $signed({9'h0, w_mant_r[23]});
    if (w_exp_r >= 10'sd255)
      w_norm_res = {r_sign, 8'hFF, 23'h0};
    else if (w_exp_r <= 10'sd0)
      w_norm_res = {r_sign, 31'h0};
    else
      w_norm_res = {r_sign, w_exp_r[7:0], w_mant_r[22:0]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = w_is_special ? S_SPECIAL : S_MULT;
      S_SPECIAL: w_next = S_IDLE;
      S_MULT:    if (r_cnt == 5'd23) w_next = S_NORM;
      S_NORM:    w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= 48'h0;
      r_ma   <= 48'h0;
      r_mb   <= 24'h0;
      r_cnt  <= 5'd0;
      r_exp  <= 10'sd0;
      r_sign <= 1'b0;
      r_res  <= 32'h0;
      r_busy <= 1'b0;
      r_rdy  <= 1'b0;
      r_m    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign <= w_sign;
            r_ma   <= {24'h0, 1'b1, a[22:0]};
            r_mb   <= {1'b1, b[22:0]};
            r_acc  <= 48'h0;
            r_cnt  <= 5'd0;
            r_exp  <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            r_res  <= w_spec_res;
            r_rdy  <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        S_MULT: begin
          if (r_mb[0]) r_acc <= r_acc + r_ma;
          r_ma  <= r_ma << 1;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + 5'd1;
        end
        S_NORM: r_res <= w_norm_res;
        S_SPECIAL, S_DONE: begin
          r_m    <= r_res;
          r_rdy  <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_f32_seq.sv
// Self-checking bench for mult_f32_seq: directed vectors, random operands
// against an arithmetic reference model, and control scenarios.
module tb_mult_f32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b, m;
  logic        busy, rdy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mult_f32_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .rdy   (rdy),
    .m     (m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer product of the significands, rounded to nearest even
  function automatic logic [31:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    logic   s;
    int     ex, ey, e, sh;
    longint p, q, rem, half;
    logic   xz, yz, xi, yi, xn, yn;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);   yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xi && yz) || (xz && yi)) return 32'h7FC00000;
    if (xi || yi) return {s, 8'hFF, 23'h0};
    if (xz || yz) return {s, 31'h0};
    p = longint'(int'(x[22:0]) + 8388608) * longint'(int'(y[22:0]) + 8388608);
    e = ex + ey - 127;
    if (p >= (longint'(1) << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (longint'(1) << 24)) begin q = longint'(1) << 23; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic bit is_special(input logic [31:0] x);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] rand_normal(input bit wide);
    logic [7:0] e;
    e = wide ? 8'($urandom_range(1, 254)) : 8'($urandom_range(90, 165));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Issue one operation; reports result, edges from accept to rdy, and
  // whether busy/rdy behaved on the way (comparisons are made by callers)
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat,
                        output bit busy_ok, output bit clr_ok);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    clr_ok  = (rdy === 1'b0) && (busy === 1'b1);
    busy_ok = 1'b1;
    lat     = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin
        lat = i;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    res = m;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy !== 1'b0)   begin failures++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (m !== 32'h0)    begin failures++; $display("FAIL reset_m got=%h exp=00000000", m); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va[13], vb[13], ve[13];
    int          vl[13];
    logic [31:0] res;
    int          lat;
    bit          bok, cok;
    va[0]  = 32'h40000000; vb[0]  = 32'h40400000; ve[0]  = 32'h40C00000; vl[0]  = 26;
    va[1]  = 32'h3FC00000; vb[1]  = 32'h3FC00000; ve[1]  = 32'h40100000; vl[1]  = 26;
    va[2]  = 32'hC0400000; vb[2]  = 32'h3F000000; ve[2]  = 32'hBFC00000; vl[2]  = 26;
    va[3]  = 32'h3F800001; vb[3]  = 32'h3F800001; ve[3]  = 32'h3F800002; vl[3]  = 26;
    va[4]  = 32'h3F800001; vb[4]  = 32'h3F7FFFFF; ve[4]  = 32'h3F800000; vl[4]  = 26;
    va[5]  = 32'h7F800000; vb[5]  = 32'h00000000; ve[5]  = 32'h7FC00000; vl[5]  = 1;
    va[6]  = 32'hFF800000; vb[6]  = 32'h40000000; ve[6]  = 32'hFF800000; vl[6]  = 1;
    va[7]  = 32'h00000001; vb[7]  = 32'h40000000; ve[7]  = 32'h00000000; vl[7]  = 1;
    va[8]  = 32'h7F000000; vb[8]  = 32'h40000000; ve[8]  = 32'h7F800000; vl[8]  = 26;
    va[9]  = 32'h00800000; vb[9]  = 32'h3F000000; ve[9]  = 32'h00000000; vl[9]  = 26;
    va[10] = 32'h3F800001; vb[10] = 32'h3FC00000; ve[10] = 32'h3FC00002; vl[10] = 26;
    va[11] = 32'h3F800003; vb[11] = 32'h3FC00000; ve[11] = 32'h3FC00004; vl[11] = 26;
    va[12] = 32'h3FFFFFFE; vb[12] = 32'h3F800001; ve[12] = 32'h40000000; vl[12] = 26;
    for (int i = 0; i < 13; i++) begin
      run_op(va[i], vb[i], res, lat, bok, cok);
      checks++; if (res !== ve[i]) begin failures++; $display("FAIL dir_result[%0d] a=%h b=%h got=%h exp=%h", i, va[i], vb[i], res, ve[i]); end
      checks++; if (lat != vl[i])  begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, vl[i]); end
      checks++; if (!bok)          begin failures++; $display("FAIL dir_busy[%0d] got=0 exp=1", i); end
      checks++; if (!cok)          begin failures++; $display("FAIL dir_accept[%0d] got=0 exp=1", i); end
      if (i == 0) begin
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdy !== 1'b1 || m !== 32'h40C00000) begin failures++; $display("FAIL dir_hold rdy=%b m=%h exp rdy=1 m=40c00000", rdy, m); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] sp[9];
    logic [31:0] x, y, res, exp_m;
    int          lat, exp_l;
    bit          bok, cok;
    sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7F800000;
    sp[3] = 32'hFF800000; sp[4] = 32'h7FC00000; sp[5] = 32'h7F800123;
    sp[6] = 32'h00000005; sp[7] = 32'h3F800000; sp[8] = 32'h40490FDB;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: begin
          x = sp[$urandom_range(0, 8)];
          y = ($urandom_range(0, 1) == 0) ? sp[$urandom_range(0, 8)] : rand_normal(1'b0);
          if ($urandom_range(0, 1) == 1) begin exp_m = x; x = y; y = exp_m; end
        end
        1, 2:    begin x = rand_normal(1'b1); y = rand_normal(1'b1); end
        default: begin x = rand_normal(1'b0); y = rand_normal(1'b0); end
      endcase
      exp_m = model_mul(x, y);
      exp_l = (is_special(x) || is_special(y)) ? 1 : 26;
      run_op(x, y, res, lat, bok, cok);
      checks++; if (res !== exp_m) begin failures++; $display("FAIL rnd_result[%0d] a=%h b=%h got=%h exp=%h", i, x, y, res, exp_m); end
      checks++; if (lat != exp_l)  begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, lat, exp_l); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    a = 32'h7F800000; b = 32'h00000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h3F800000; b = 32'h3F800000;
    lat = -1;
    for (int i = 7; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin lat = i; break; end
    end
    checks++; if (m !== 32'h40C00000) begin failures++; $display("FAIL ignore_result got=%h exp=40c00000", m); end
    checks++; if (lat != 26)          begin failures++; $display("FAIL ignore_latency got=%0d exp=26", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat;
    bit          bok, cok;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0)  begin failures++; $display("FAIL midrst_rdy got=%b exp=0", rdy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (m !== 32'h0)   begin failures++; $display("FAIL midrst_m got=%h exp=00000000", m); end
    @(negedge clk); rst = 1'b0;
    run_op(32'h3FC00000, 32'h3FC00000, res, lat, bok, cok);
    checks++; if (res !== 32'h40100000) begin failures++; $display("FAIL midrst_after got=%h exp=40100000", res); end
    checks++; if (lat != 26)            begin failures++; $display("FAIL midrst_latency got=%0d exp=26", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, res, exp_m;
    int          lat, prev_cyc, gap;
    bit          bok, cok;
    prev_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      x = rand_normal(1'b0); y = rand_normal(1'b0);
      exp_m = model_mul(x, y);
      run_op(x, y, res, lat, bok, cok);
      checks++; if (res !== exp_m) begin failures++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, res, exp_m); end
      checks++; if (!cok)          begin failures++; $display("FAIL b2b_rdy_drop[%0d] got=0 exp=1", i); end
      if (prev_cyc >= 0) begin
        gap = cyc - prev_cyc;
        checks++; if (gap != 27) begin failures++; $display("FAIL b2b_throughput[%0d] got=%0d exp=27", i, gap); end
      end
      prev_cyc = cyc;
    end
  endtask

  initial begin
    start = 1'b0; a = 32'h0; b = 32'h0; rst = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_f32_seq.md
# mult_f32_seq

Sequential IEEE-754 single-precision multiplier, m = a * b. It computes the 24x24 mantissa product with a one-bit-per-cycle shift-add datapath, then normalizes and rounds it. It is the multiply-side counterpart to the iterative divide/reciprocal units in the processing element, and shares their clk/rst/rdy conventions. It is intended for area-constrained PE variants where a combinational multiplier array is too large.

## Interface
Parameters:
- none. Width is fixed at 32 bits: 1 sign, 8 exponent, 23 mantissa, bias 127.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  request; sampled on a rising edge while busy=0
- a  in  32  operand A (float32); captured only when start is accepted
- b  in  32  operand B (float32); captured only when start is accepted
- busy  out  1  high while a multiply is in progress
- rdy  out  1  result valid; held until the next accepted start
- m  out  32  product (float32); held stable while rdy=1

## Operation
- Reset values: rdy=0, busy=0, m=32'h0, state=IDLE, iteration counter=0.
- **IDLE:**
  - start=1 at an edge latches a, b and the sign (a[31]^b[31]).
  - The same edge clears rdy and sets busy.
  - Special operands (checked at the start edge) route to SPECIAL; all others route to MULT.
- **Special operands (SPECIAL, 1 cycle):**
  - An exponent of 0 counts as zero; denormal inputs flush to zero.
  - NaN input, or Inf*0 → m=32'h7FC00000.
  - Inf*finite-nonzero or Inf*Inf → signed Inf.
  - Zero*finite → signed zero.
- **MULT (24 cycles):**
  - ma={1,a[22:0]}, mb={1,b[22:0]}, 48-bit accumulator.
  - Each cycle: if mb[i]=1, acc += ma<<i, for i=0..23 (shift-register form is acceptable).
  - Exponent sum e = ea + eb - 127, computed in 10-bit signed.
- **NORM (1 cycle):**
  - If acc[47]=1: mantissa = acc[46:24], guard = acc[23], sticky = |acc[22:0], e += 1.
  - Else: mantissa = acc[45:23], guard = acc[22], sticky = |acc[21:0].
  - Round to nearest, ties to even. A rounding carry out of the mantissa sets e += 1 and mantissa = 0.
  - e >= 255 → signed Inf (32'h7F800000 | sign).
  - e <= 0 → signed zero (flush; no denormal outputs).
- **DONE:**
  - m is written, rdy=1, busy=0, and the state returns to IDLE.
  - m and rdy hold until a new start is accepted.
- start while busy=1 is ignored, with no effect on the operation in flight.
- start and rdy=1 together: the new operands are accepted and rdy drops on the same edge.
- rst=1 at any edge, including mid-MULT, restores all reset values on that edge; the operation in flight is discarded.
- Changes on a or b after acceptance have no effect on the result.

## Timing
- Accepting edge = edge k.
- Normal operands:
  - MULT occupies edges k+1..k+24.
  - NORM occupies edge k+25.
  - m/rdy are updated at edge k+26, so latency is 26 cycles.
- Special operands: m/rdy are updated at edge k+1, so latency is 1 cycle.
- busy goes high at edge k and low on the edge that sets rdy.
- Throughput: one result per 27 cycles when start is reissued in the cycle after rdy.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- 2.0*3.0: a=32'h40000000, b=32'h40400000 → m=32'h40C00000; rdy rises exactly 26 edges after the start edge; busy is high throughout.
- Normalize and sign: 1.5*1.5 (32'h3FC00000 twice) → 32'h40100000. Then -3.0*0.5 (32'hC0400000, 32'h3F000000) → 32'hBFC00000.
- Rounding: 32'h3F800001*32'h3F800001 → 32'h3F800002. 32'h3F800001*32'h3F7FFFFF → 32'h3F800000 (tie case absent; round down).
- Specials:
  - Inf*0 (32'h7F800000, 32'h0) → 32'h7FC00000 with 1-cycle latency.
  - -Inf*2.0 → 32'hFF800000.
  - Denormal 32'h00000001 * 2.0 → 32'h00000000.
- Range: 32'h7F000000*32'h40000000 → 32'h7F800000. 32'h00800000*32'h3F000000 → 32'h00000000.
- Control:
  - start pulsed mid-MULT with different operands → ignored; the original result is delivered.
  - rst asserted at iteration 10 → rdy=0, busy=0, m=0 at that edge; a fresh start then completes normally in 26 cycles.
